pcre_chain_engine: RTL

Parametrised one-hot NFA engine for a single Snort PCRE content chain, with per-state character-class selection, self-loops, optional-state bypass, an anchored/unanchored mode, and per-packet match reporting. It sits in the payload engine after the shared character-class decoder, which broadcasts one decoded class vector per payload byte. It replaces the fixed, per-rule hand-wired engines with one configurable block instantiated per rule.

---
 rtl/pcre_chain_engine.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pcre_chain_engine.sv
// pcre_chain_engine: one-hot NFA for a single PCRE content chain.
// Each state is gated by one decoded class line and fed by its predecessor,
// optionally by itself (self-loop) and by the state two back (optional-state
// bypass). Match ends are reported per byte and summarised per packet.
module pcre_chain_engine #(
    parameter int                                  N_STATES  = 30,
    parameter int                                  N_CLASS   = 32,
    parameter logic [N_STATES*$clog2(N_CLASS)-1:0] CLS_IDX   = '0,
    parameter logic [N_STATES-1:0]                 LOOP_MASK = '0,
    parameter logic [N_STATES-1:0]                 SKIP_MASK = '0,
    parameter bit                                  ANCHOR    = 1'b0,
    parameter int                                  OFF_W     = 16,
    parameter int                                  CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sod,
    input  logic               eod,
    input  logic               en,
    input  logic [N_CLASS-1:0] cls_in,
    output logic               match_pulse,
    output logic               match,
    output logic [OFF_W-1:0]   match_off,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               res_valid,
    output logic               res_match
);
    localparam int CIW = $clog2(N_CLASS);

    // st[i-1] holds state i of the chain
    logic [N_STATES-1:0] st;
    logic [N_STATES-1:0] st_next;
    // pv[k+1] is P[k] (start token at pv[1]); pv[0] is a constant-zero pad
    // so that the "two states back" tap of state 1 stays in range
    logic [N_STATES+1:0] pv;
    logic [CIW-1:0]      cidx;
    logic                skip_src;
    logic                hit;

    logic [OFF_W-1:0]    off;
    logic [OFF_W-1:0]    cur_off;

    logic                match_next;
    logic [OFF_W-1:0]    moff_next;
    logic [CNT_W-1:0]    cnt_next;

    function automatic logic [OFF_W-1:0] sat_inc_off(input logic [OFF_W-1:0] v);
        return (&v) ? v : v + {{(OFF_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Next state of every chain position for the byte currently presented
    always_comb begin
        pv       = '0;
        cidx     = '0;
        skip_src = 1'b0;
        st_next  = '0;
        pv[1]    = ANCHOR ? sod : 1'b1;
        if (!sod) begin
            pv[N_STATES+1:2] = st;
        end
        for (int i = 1; i <= N_STATES; i++) begin
            cidx     = CLS_IDX[(i-1)*CIW +: CIW];
            skip_src = (i >= 2) ? (SKIP_MASK[i-1] & pv[i-1]) : 1'b0;
            st_next[i-1] = cls_in[cidx] &
                           (pv[i] | (LOOP_MASK[i-1] & pv[i+1]) | skip_src);
        end
    end

    assign hit     = st_next[N_STATES-1];
    assign cur_off = sod ? '0 : off;

    // Packet-scoped match summary as it stands after the current byte
    always_comb begin
        match_next = sod ? 1'b0 : match;
        moff_next  = sod ? '0 : match_off;
        cnt_next   = sod ? '0 : match_cnt;
        if (hit) begin
            cnt_next = sat_inc_cnt(cnt_next);
            if (!match_next) begin
                moff_next = cur_off;
            end
            match_next = 1'b1;
        end
    end

    // Chain state and byte offset: advance per accepted byte, clear at packet end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= '0;
            off <= '0;
        end else if (en) begin
            if (eod) begin
                st  <= '0;
                off <= '0;
            end else begin
                st  <= st_next;
                off <= sat_inc_off(cur_off);
            end
        end
    end

    // Match reporting: pulse per match end, sticky flag, first offset, count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_pulse <= 1'b0;
            match       <= 1'b0;
            match_off   <= '0;
            match_cnt   <= '0;
        end else if (en) begin
            match_pulse <= hit;
            match       <= match_next;
            match_off   <= moff_next;
            match_cnt   <= cnt_next;
        end else begin
            match_pulse <= 1'b0;
        end
    end

    // Per-packet result strobe, one cycle after the last byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_match <= 1'b0;
        end else begin
            res_valid <= en & eod;
            if (en & eod) begin
                res_match <= match_next;
            end
        end
    end

endmodule
